trb_pkt_dispatch: RTL and testbench
===================================

// Module: trb_pkt_dispatch
// PURPOSE
//  Packet-granular round-robin dispatcher in the clk_st domain, between the bus FIFO read side and
//  the NUM_TURBO bus2st_turbo lanes. Locks one lane per turbo packet (NUM_BUS_PER_TURBO_PKT beats),
//  skips lanes that are not ready at packet start, stalls (never re-routes) on mid-packet backpressure.
// PARAMETERS
//  BUS                    534  data width of one bus beat
//  NUM_TURBO              2    number of decoder lanes, 1..16
//  NUM_BUS_PER_TURBO_PKT  25   beats per turbo packet, 2..511
// PORTS
//  clk_st      in   1          clock
//  rst         in   1          asynchronous reset, active high
//  in_data     in   BUS        beat from FIFO
//  in_valid    in   1          in_data valid
//  in_ready    out  1          dispatcher accepts beat this cycle (combinational)
//  lane_ready  in   NUM_TURBO  per-lane ready (bus_ready of each bus2st_turbo)
//  lane_en     out  NUM_TURBO  per-lane beat strobe, one-hot or zero
//  lane_data   out  BUS        beat to lanes, shared by all lanes
//  grant       out  4          currently locked lane index
//  busy        out  1          1 while a packet is in progress (state XFER)
//  pkt_done    out  1          1-cycle pulse, last beat of a packet accepted
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE, rr_ptr=NUM_TURBO-1, beat_cnt=0, grant=0; lane_en=0,
//   lane_data=0, busy=0, pkt_done=0, in_ready=0. Reset mid-packet drops the partial packet;
//   no recovery beat or flush is generated.
//  Accept: acc = in_valid & in_ready. in_ready = (state==XFER) & lane_ready[grant]; no other term.
//  FSM:
//   IDLE: search lanes rr_ptr+1, rr_ptr+2, ... modulo NUM_TURBO; first with lane_ready=1 wins.
//         If found: grant<=winner, beat_cnt<=0, state<=XFER. None ready: stay IDLE, in_ready=0.
//   XFER: on acc beat_cnt<=beat_cnt+1. On acc with beat_cnt==NUM_BUS_PER_TURBO_PKT-1:
//         beat_cnt<=0, rr_ptr<=grant, pkt_done<=1 (next cycle), state<=IDLE.
//         lane_ready[grant]=0 stalls: in_ready=0, grant and beat_cnt hold; lane never changes mid-packet.
//  Inter-packet bubble: exactly one IDLE cycle between last beat of packet N and first beat of N+1.
//  Datapath latency 1: on acc, next cycle lane_en[grant]=1 and lane_data=in_data; otherwise
//   lane_en=0 and lane_data holds last value.
//  in_valid gaps inside a packet are legal; only accepted beats count.
//  rr_ptr updates only on packet completion; a lane skipped as not-ready keeps its turn order.
//  beat_cnt width 9 bits; never exceeds NUM_BUS_PER_TURBO_PKT-1.
//  grant zero-extended to 4 bits; busy = (state==XFER).
//  NUM_TURBO=1: search always yields lane 0; behaviour otherwise identical.
//  lane_ready changing during the IDLE search cycle is sampled that cycle only (registered decision).
// TESTING
//  1 both lanes ready, 3 packets of 25 beats, in_valid=1 -> lanes 0,1,0; lane_en pulses 25 per
//    packet, 1 bubble between packets, 3 pkt_done pulses, lane_data matches in_data delayed 1 cycle.
//  2 lane_ready=2'b10 at start -> packet 1 to lane 1; set 2'b11 -> packet 2 to lane 0, packet 3 lane 1.
//  3 lane_ready[grant]=0 for 5 cycles after beat 10 -> in_ready=0 for those 5 cycles, grant holds,
//    beats 11..24 continue to same lane, exactly 25 lane_en pulses total.
//  4 lane_ready=0 all lanes, in_valid=1 for 100 cycles -> busy=0, in_ready=0, lane_en=0 throughout.
//  5 rst pulsed after beat 12 -> all outputs 0 immediately; after release, next packet on lane 0,
//    25 beats counted from 0.
//  6 in_valid toggling every other cycle -> 25 accepted beats form one packet, pkt_done once on beat 25.

Source files
------------

// File: rtl/trb_pkt_dispatch.sv
// Packet-granular round-robin dispatcher: locks one turbo lane per packet, skips lanes
// that are not ready at packet start and stalls in place on mid-packet backpressure.
module trb_pkt_dispatch #(
  parameter int BUS                   = 534,
  parameter int NUM_TURBO             = 2,
  parameter int NUM_BUS_PER_TURBO_PKT = 25
) (
  input  logic                 clk_st,
  input  logic                 rst,
  input  logic [BUS-1:0]       in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_TURBO-1:0] lane_ready,
  output logic [NUM_TURBO-1:0] lane_en,
  output logic [BUS-1:0]       lane_data,
  output logic [3:0]           grant,
  output logic                 busy,
  output logic                 pkt_done
);

  typedef enum logic {IDLE, XFER} state_e;

  localparam logic [8:0] LAST_BEAT = 9'(NUM_BUS_PER_TURBO_PKT - 1);
  localparam logic [3:0] PTR_RESET = 4'(NUM_TURBO - 1);
  localparam logic [4:0] NUM_LANES = 5'(NUM_TURBO);

  state_e               state_q, state_d;
  logic [3:0]           rr_ptr_q, rr_ptr_d;
  logic [3:0]           grant_q, grant_d;
  logic [8:0]           beat_cnt_q, beat_cnt_d;
  logic                 pkt_done_q, pkt_done_d;
  logic [NUM_TURBO-1:0] lane_en_q, lane_en_d;
  logic [BUS-1:0]       lane_data_q, lane_data_d;

  logic [15:0]          ready_pad;
  logic                 grant_ready;
  logic                 acc;
  logic                 last_beat;
  logic                 found;
  logic [3:0]           winner;
  logic [4:0]           cand;

  // Padding to 16 lanes lets the 4-bit grant index any lane count without a range check.
  assign ready_pad   = 16'(lane_ready);
  assign grant_ready = ready_pad[grant_q];
  assign acc         = in_valid & in_ready;
  assign last_beat   = (beat_cnt_q == LAST_BEAT);

  // Search starts one past the last completed lane; rr_ptr < NUM_TURBO so one wrap suffices.
  always_comb begin
    found  = 1'b0;
    winner = 4'd0;
    cand   = 5'd0;
    for (int i = 1; i <= NUM_TURBO; i++) begin
      cand = 5'(rr_ptr_q) + 5'(i);
      if (cand >= NUM_LANES) begin
        cand = cand - NUM_LANES;
      end
      if (!found && ready_pad[cand[3:0]]) begin
        found  = 1'b1;
        winner = cand[3:0];
      end
    end
  end

  always_ff @(posedge clk_st or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= PTR_RESET;
      grant_q    <= 4'd0;
      beat_cnt_q <= 9'd0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    pkt_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = winner;
          beat_cnt_d = 9'd0;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (acc) begin
          if (last_beat) begin
            beat_cnt_d = 9'd0;
            rr_ptr_d   = grant_q;
            pkt_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 9'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A stalled lane only blocks acceptance; the lock itself never moves mid-packet.
  always_comb begin
    busy     = (state_q == XFER);
    in_ready = (state_q == XFER) & grant_ready;
  end

  always_comb begin
    lane_en_d   = '0;
    lane_data_d = lane_data_q;
    if (acc) begin
      lane_en_d   = NUM_TURBO'(16'd1 << grant_q);
      lane_data_d = in_data;
    end
  end

  always_ff @(posedge clk_st or posedge rst) begin
    if (rst) begin
      lane_en_q   <= '0;
      lane_data_q <= '0;
    end else begin
      lane_en_q   <= lane_en_d;
      lane_data_q <= lane_data_d;
    end
  end

  assign lane_en   = lane_en_q;
  assign lane_data = lane_data_q;
  assign grant     = grant_q;
  assign pkt_done  = pkt_done_q;

endmodule

// File: tb/tb_trb_pkt_dispatch.sv
// Bench for trb_pkt_dispatch: reference model feeds a beat scoreboard, packet scenarios come
// from a vector table, and stall / no-ready / mid-packet reset are hand-written sequences.
module tb_trb_pkt_dispatch;

  localparam int BUS = 534;
  localparam int NT  = 2;
  localparam int PKT = 25;

  logic           clk_st;
  logic           rst;
  logic [BUS-1:0] in_data;
  logic           in_valid;
  logic           in_ready;
  logic [NT-1:0]  lane_ready;
  logic [NT-1:0]  lane_en;
  logic [BUS-1:0] lane_data;
  logic [3:0]     grant;
  logic           busy;
  logic           pkt_done;

  trb_pkt_dispatch #(
    .BUS(BUS),
    .NUM_TURBO(NT),
    .NUM_BUS_PER_TURBO_PKT(PKT)
  ) dut (
    .clk_st(clk_st),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .lane_ready(lane_ready),
    .lane_en(lane_en),
    .lane_data(lane_data),
    .grant(grant),
    .busy(busy),
    .pkt_done(pkt_done)
  );

  typedef struct packed {
    logic [3:0]     lane;
    logic [BUS-1:0] data;
  } sbItem_t;

  typedef struct {
    logic [1:0]  readyStart;
    logic [1:0]  readyLater;
    bit          toggleValid;
    int          numPkts;
    logic [11:0] expLanes;
  } vec_t;

  sbItem_t sbq[$];
  int      doneLanes[$];
  vec_t    vecs[4];

  int errors;
  int checks;
  int seq;
  int doneCnt;
  int pulseCnt[2];
  bit chkEn;

  logic           mBusy;
  logic [3:0]     mLane;
  int             mPtr;
  int             mCount;
  logic           mDone;
  logic [BUS-1:0] mData;

  initial clk_st = 1'b0;
  always #5 clk_st = ~clk_st;

  function automatic logic readyOf(input logic [1:0] r, input int l);
    logic [15:0] rp;
    rp = 16'(r);
    return rp[l[3:0]];
  endfunction

  function automatic int searchLane(input logic [1:0] r, input int ptr);
    for (int k = 1; k <= NT; k++) begin
      if (readyOf(r, (ptr + k) % NT)) return (ptr + k) % NT;
    end
    return -1;
  endfunction

  function automatic logic [BUS-1:0] makeData(input int n);
    logic [BUS-1:0] d;
    d = '0;
    d[31:0]        = 32'(n);
    d[300 +: 32]   = 32'(n) * 32'h9E3779B1;
    d[BUS-1 -: 32] = ~32'(n);
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [BUS-1:0] actual,
                             input logic [BUS-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid);
    in_valid = valid;
    in_data  = makeData(seq);
    seq++;
  endtask

  task automatic clearCounters();
    doneCnt     = 0;
    pulseCnt[0] = 0;
    pulseCnt[1] = 0;
    doneLanes.delete();
  endtask

  task automatic doResetPulse();
    @(negedge clk_st);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk_st);
    rst = 1'b0;
    clearCounters();
  endtask

  // Reference model: decides acceptance and lane from the behaviour description and
  // pushes every accepted beat to the scoreboard.
  always @(posedge clk_st or posedge rst) begin
    if (rst) begin
      mBusy  <= 1'b0;
      mLane  <= 4'd0;
      mPtr   <= NT - 1;
      mCount <= 0;
      mDone  <= 1'b0;
      mData  <= '0;
      sbq.delete();
    end else begin
      mDone <= 1'b0;
      if (!mBusy) begin
        if (searchLane(lane_ready, mPtr) >= 0) begin
          mBusy  <= 1'b1;
          mLane  <= 4'(searchLane(lane_ready, mPtr));
          mCount <= 0;
        end
      end else if (in_valid && readyOf(lane_ready, int'(mLane))) begin
        sbq.push_back({mLane, in_data});
        mData <= in_data;
        if (mCount == PKT - 1) begin
          mCount <= 0;
          mPtr   <= int'(mLane);
          mDone  <= 1'b1;
          mBusy  <= 1'b0;
        end else begin
          mCount <= mCount + 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model plus the beat scoreboard.
  always @(posedge clk_st) begin
    sbItem_t item;
    #2;
    if (chkEn && !rst) begin
      checkOutput("in_ready", BUS'(in_ready), BUS'(mBusy && readyOf(lane_ready, int'(mLane))));
      checkOutput("busy", BUS'(busy), BUS'(mBusy));
      checkOutput("grant", BUS'(grant), BUS'(mLane));
      checkOutput("pkt_done", BUS'(pkt_done), BUS'(mDone));
      checkOutput("lane_data_hold", lane_data, mData);
      if (lane_en !== '0) begin
        if (lane_en[0] === 1'b1) pulseCnt[0]++;
        if (lane_en[1] === 1'b1) pulseCnt[1]++;
        if (sbq.size() == 0) begin
          checkOutput("sb_unexpected_beat", BUS'(lane_en), BUS'(0));
        end else begin
          item = sbq.pop_front();
          checkOutput("sb_lane_en", BUS'(lane_en), BUS'(16'd1 << item.lane));
          checkOutput("sb_lane_data", lane_data, item.data);
        end
      end
      if (sbq.size() != 0) begin
        checkOutput("sb_missing_beat", BUS'(lane_en), BUS'(16'd1 << sbq[0].lane));
        sbq.delete();
      end
      if (pkt_done === 1'b1) begin
        doneCnt++;
        doneLanes.push_back(lane_en[1] === 1'b1 ? 1 : 0);
      end
    end
  end

  task automatic runVector(input vec_t v, input int idx);
    int budget;
    int expCnt[2];
    doResetPulse();
    lane_ready = v.readyStart;
    budget     = 0;
    while (doneCnt < v.numPkts && budget < v.numPkts * 100) begin
      @(negedge clk_st);
      budget++;
      if (doneCnt >= 1) lane_ready = v.readyLater;
      applyStimulus(v.toggleValid ? budget[0] : 1'b1);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk_st);
    $display("[TB] vector %0d done after %0d cycles", idx, budget);
    checkOutput("vec_pkt_count", BUS'(doneCnt), BUS'(v.numPkts));
    expCnt[0] = 0;
    expCnt[1] = 0;
    for (int k = 0; k < v.numPkts; k++) begin
      expCnt[int'(v.expLanes[4*k +: 4])] += PKT;
      if (k < doneLanes.size())
        checkOutput("vec_pkt_lane", BUS'(doneLanes[k]), BUS'(v.expLanes[4*k +: 4]));
    end
    checkOutput("vec_pulses_lane0", BUS'(pulseCnt[0]), BUS'(expCnt[0]));
    checkOutput("vec_pulses_lane1", BUS'(pulseCnt[1]), BUS'(expCnt[1]));
  endtask

  task automatic runStall();
    int budget;
    doResetPulse();
    lane_ready = 2'b11;
    budget     = 0;
    while (pulseCnt[0] < 11 && budget < 200) begin
      @(negedge clk_st);
      budget++;
      applyStimulus(1'b1);
    end
    checkOutput("stall_reach_beat10", BUS'(pulseCnt[0]), BUS'(11));
    lane_ready = 2'b10;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_st);
      #2;
      checkOutput("stall_in_ready", BUS'(in_ready), BUS'(0));
      checkOutput("stall_grant", BUS'(grant), BUS'(0));
      checkOutput("stall_busy", BUS'(busy), BUS'(1));
      checkOutput("stall_lane_en", BUS'(lane_en), BUS'(0));
      @(negedge clk_st);
      applyStimulus(1'b1);
    end
    lane_ready = 2'b11;
    budget     = 0;
    while (doneCnt < 1 && budget < 200) begin
      @(negedge clk_st);
      budget++;
      applyStimulus(1'b1);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk_st);
    checkOutput("stall_pkt_count", BUS'(doneCnt), BUS'(1));
    checkOutput("stall_pulses_lane0", BUS'(pulseCnt[0]), BUS'(PKT));
    checkOutput("stall_pulses_lane1", BUS'(pulseCnt[1]), BUS'(0));
    if (doneLanes.size() > 0) checkOutput("stall_pkt_lane", BUS'(doneLanes[0]), BUS'(0));
  endtask

  task automatic runNoReady();
    doResetPulse();
    lane_ready = 2'b00;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_st);
      applyStimulus(1'b1);
      @(posedge clk_st);
      #2;
      checkOutput("noready_busy", BUS'(busy), BUS'(0));
      checkOutput("noready_in_ready", BUS'(in_ready), BUS'(0));
      checkOutput("noready_lane_en", BUS'(lane_en), BUS'(0));
    end
    in_valid = 1'b0;
  endtask

  task automatic runMidReset();
    int budget;
    doResetPulse();
    lane_ready = 2'b11;
    budget     = 0;
    while (pulseCnt[0] < 13 && budget < 200) begin
      @(negedge clk_st);
      budget++;
      applyStimulus(1'b1);
    end
    checkOutput("midrst_reach_beat12", BUS'(pulseCnt[0]), BUS'(13));
    rst = 1'b1;
    #1;
    checkOutput("midrst_lane_en", BUS'(lane_en), BUS'(0));
    checkOutput("midrst_lane_data", lane_data, BUS'(0));
    checkOutput("midrst_busy", BUS'(busy), BUS'(0));
    checkOutput("midrst_pkt_done", BUS'(pkt_done), BUS'(0));
    checkOutput("midrst_in_ready", BUS'(in_ready), BUS'(0));
    checkOutput("midrst_grant", BUS'(grant), BUS'(0));
    @(negedge clk_st);
    rst = 1'b0;
    clearCounters();
    budget = 0;
    while (doneCnt < 1 && budget < 200) begin
      @(negedge clk_st);
      budget++;
      applyStimulus(1'b1);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk_st);
    checkOutput("midrst_pkt_count", BUS'(doneCnt), BUS'(1));
    checkOutput("midrst_pulses_lane0", BUS'(pulseCnt[0]), BUS'(PKT));
    checkOutput("midrst_pulses_lane1", BUS'(pulseCnt[1]), BUS'(0));
    if (doneLanes.size() > 0) checkOutput("midrst_pkt_lane", BUS'(doneLanes[0]), BUS'(0));
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    seq        = 0;
    chkEn      = 1'b0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    lane_ready = '0;
    clearCounters();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk_st);
    checkOutput("reset_in_ready", BUS'(in_ready), BUS'(0));
    checkOutput("reset_busy", BUS'(busy), BUS'(0));
    checkOutput("reset_lane_en", BUS'(lane_en), BUS'(0));
    checkOutput("reset_lane_data", lane_data, BUS'(0));
    checkOutput("reset_grant", BUS'(grant), BUS'(0));
    checkOutput("reset_pkt_done", BUS'(pkt_done), BUS'(0));
    chkEn = 1'b1;

    vecs[0] = '{2'b11, 2'b11, 1'b0, 3, 12'h010};
    vecs[1] = '{2'b10, 2'b11, 1'b0, 3, 12'h101};
    vecs[2] = '{2'b11, 2'b11, 1'b1, 1, 12'h000};
    vecs[3] = '{2'b01, 2'b01, 1'b0, 2, 12'h000};
    for (int i = 0; i < 4; i++) runVector(vecs[i], i);

    runStall();
    runNoReady();
    runMidReset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
